board_io_ctrl: RTL
==================

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits (legal 1..8).
REQ-002 SHALL have parameter NUM_KEYS, default 4, number of pushbuttons (legal 1..8).
REQ-003 SHALL have parameter NUM_SW, default 10, number of slider switches (legal 1..16).
REQ-004 SHALL have parameter NUM_LEDS, default 10, number of LEDs (legal 1..16).
REQ-005 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles required to accept a key change (legal >=2).
REQ-006 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 read  input  1  read strobe; write  input  1  write strobe.
REQ-009 writedata  input  32  write data; readdata  output  32  read data; readdatavalid  output  1  read data qualifier.
REQ-010 key_n  input  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk.
REQ-011 sw  input  NUM_SW  raw switches, asynchronous to clk.
REQ-012 hex  output  7*NUM_DIGITS  segments, active-low, digit i in bits [7i+6:7i].
REQ-013 ledr  output  NUM_LEDS  LED drive, active-high; irq  output  1  key-press interrupt, active-high.

Function
REQ-014 Register map SHALL be: 0 HEX_DATA (RW, nibble i = digit i); 1 HEX_BLANK (RW, bit i blanks digit i); 2 KEY_STATE (RO); 3 KEY_EDGE (RW1C); 4 SW_STATE (RO); 5 LEDR (RW); 6 IRQ_MASK (RW); 7 reserved.
REQ-015 Only implemented low bits SHALL be stored; unimplemented bits read 0; writes to RO/reserved addresses are ignored; reserved reads return 0.
REQ-016 Read latency SHALL be exactly 1: readdata registered and readdatavalid high for one cycle after each cycle with read=1; readdata holds 0 when readdatavalid=0.
REQ-017 Read and write in the same cycle SHALL return the pre-write value and then apply the write.
REQ-018 Each key_n and sw bit SHALL pass through a 2-flop synchroniser; SW_STATE = synchronised sw (2-cycle latency, no debounce).
REQ-019 Each key SHALL have its own debounce counter: counter resets to 0 whenever synchronised pressed (= ~key_n) equals debounced state; otherwise increments; when it reaches DEBOUNCE_CYCLES-1 the debounced state toggles and counter clears.
REQ-020 KEY_STATE bit i SHALL be debounced pressed state of key i (1 = pressed).
REQ-021 KEY_EDGE bit i SHALL set on the cycle debounced state i goes 0->1 and remain set until written 1; writing 0 leaves it unchanged.
REQ-022 Simultaneous set and W1C clear on the same KEY_EDGE bit SHALL leave the bit set.
REQ-023 irq SHALL be registered, equal to |(KEY_EDGE & IRQ_MASK) one cycle after those registers change.
REQ-024 Digit i SHALL output standard hex 0-F active-low glyphs (0 = 7'h40, 8 = 7'h00, F = 7'h0E), or 7'h7F when HEX_BLANK bit i is 1; hex is registered, 1 cycle after register update.
REQ-025 ledr SHALL equal the LEDR register directly.

Reset
REQ-026 On reset assertion all state SHALL clear asynchronously: HEX_DATA=0, HEX_BLANK=all ones, LEDR=0, IRQ_MASK=0, KEY_EDGE=0, debounced keys=0 (released), counters=0, synchronisers=0 (key path to released), readdata=0, readdatavalid=0, irq=0.
REQ-027 Therefore during and after reset hex SHALL be all 7'h7F, ledr 0, irq 0.
REQ-028 Reset asserted mid-transaction SHALL drop any pending readdatavalid; no register update from the interrupted cycle is retained.
REQ-029 Key held pressed through reset release SHALL still require DEBOUNCE_CYCLES stable cycles before KEY_STATE/KEY_EDGE assert.

Verification (DEBOUNCE_CYCLES=4, defaults otherwise)
REQ-030 Reset release -> hex all 7'h7F, ledr=0, irq=0; read addr 1 -> readdata=0x3F next cycle with readdatavalid=1.
REQ-031 Write addr0=0x00F821, addr1=0 -> next cycle digits 0..5 = 7'h79,7'h24,7'h00,7'h0E,7'h40,7'h40.
REQ-032 key_n[2] low 10 cycles -> KEY_STATE=0x4 and KEY_EDGE=0x4; 3-cycle glitch -> no change.
REQ-033 IRQ_MASK=0x4 then press key 2 -> irq=1; write addr3=0x4 on edge-set cycle -> bit stays set; later W1C -> irq=0 one cycle after.
REQ-034 Read addr 4 with sw=0x2A5 -> 0x2A5; read addr 7 -> 0; read+write addr5 same cycle -> old value, then new ledr.
REQ-035 Reset pulsed while key held and LEDR=0x3FF -> ledr=0, KEY_STATE=0, re-asserts after 4 stable cycles post-synchroniser.

Source files
------------

// File: rtl/board_io_ctrl_if.sv
// Avalon-MM slave bus for the board I/O register block: word address,
// read/write strobes, and registered read data with its qualifier.
interface board_io_ctrl_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O register block: seven-segment digits, debounced pushbuttons with
// edge interrupt, synchronised switches and LEDs behind an Avalon-MM slave.
module board_io_ctrl #(
    parameter int NUM_DIGITS      = 6,
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int NUM_LEDS        = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    board_io_ctrl_if.slave          avs,
    input  logic [NUM_KEYS-1:0]     key_n,
    input  logic [NUM_SW-1:0]       sw,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic [NUM_LEDS-1:0]     ledr,
    output logic                    irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        A_HEX_DATA  = 3'd0,
        A_HEX_BLANK = 3'd1,
        A_KEY_STATE = 3'd2,
        A_KEY_EDGE  = 3'd3,
        A_SW_STATE  = 3'd4,
        A_LEDR      = 3'd5,
        A_IRQ_MASK  = 3'd6,
        A_RESERVED  = 3'd7
    } reg_addr_e;

    reg_addr_e                addr;
    logic [4*NUM_DIGITS-1:0]  hex_data;
    logic [NUM_DIGITS-1:0]    hex_blank;
    logic [NUM_KEYS-1:0]      irq_mask;
    logic [NUM_KEYS-1:0]      key_edge;
    logic [NUM_KEYS-1:0]      key_meta;
    logic [NUM_KEYS-1:0]      key_sync;
    logic [NUM_KEYS-1:0]      key_db;
    logic [NUM_KEYS-1:0]      key_done;
    logic [NUM_KEYS-1:0]      key_rise;
    logic [NUM_KEYS-1:0]      edge_clr;
    logic [CNT_W-1:0]         key_cnt [NUM_KEYS];
    logic [NUM_SW-1:0]        sw_meta;
    logic [NUM_SW-1:0]        sw_sync;
    logic [31:0]              rd_mux;
    logic [7*NUM_DIGITS-1:0]  hex_next;
    logic                     unused_wdata;

    assign addr         = reg_addr_e'(avs.address);
    assign unused_wdata = ^avs.writedata;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = 7'h7F;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Key path carries "pressed" so a cleared synchroniser means released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta <= '0;
            key_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= ~key_n;
            key_sync <= key_meta;
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
        end
    end

    always_comb begin
        key_done = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            key_done[i] = (key_sync[i] != key_db[i]) && (key_cnt[i] == CNT_MAX);
        end
        key_rise = key_done & key_sync;
        edge_clr = (avs.write && addr == A_KEY_EDGE) ? avs.writedata[NUM_KEYS-1:0] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_db  <= '0;
            key_cnt <= '{default: '0};
        end else begin
            key_db <= key_db ^ key_done;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (key_sync[i] == key_db[i] || key_done[i]) begin
                    key_cnt[i] <= '0;
                end else begin
                    key_cnt[i] <= key_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Read mux sees pre-write register values, so read+write returns old data.
    always_comb begin
        rd_mux = '0;
        case (addr)
            A_HEX_DATA:  rd_mux[4*NUM_DIGITS-1:0] = hex_data;
            A_HEX_BLANK: rd_mux[NUM_DIGITS-1:0]   = hex_blank;
            A_KEY_STATE: rd_mux[NUM_KEYS-1:0]     = key_db;
            A_KEY_EDGE:  rd_mux[NUM_KEYS-1:0]     = key_edge;
            A_SW_STATE:  rd_mux[NUM_SW-1:0]       = sw_sync;
            A_LEDR:      rd_mux[NUM_LEDS-1:0]     = ledr;
            A_IRQ_MASK:  rd_mux[NUM_KEYS-1:0]     = irq_mask;
            A_RESERVED:  rd_mux = '0;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_data          <= '0;
            hex_blank         <= '1;
            ledr              <= '0;
            irq_mask          <= '0;
            key_edge          <= '0;
            avs.readdata      <= '0;
            avs.readdatavalid <= 1'b0;
            irq               <= 1'b0;
        end else begin
            if (avs.write && addr == A_HEX_DATA)  hex_data  <= avs.writedata[4*NUM_DIGITS-1:0];
            if (avs.write && addr == A_HEX_BLANK) hex_blank <= avs.writedata[NUM_DIGITS-1:0];
            if (avs.write && addr == A_LEDR)      ledr      <= avs.writedata[NUM_LEDS-1:0];
            if (avs.write && addr == A_IRQ_MASK)  irq_mask  <= avs.writedata[NUM_KEYS-1:0];
            // A fresh rising edge wins over a same-cycle write-1-to-clear.
            key_edge          <= (key_edge & ~edge_clr) | key_rise;
            avs.readdata      <= avs.read ? rd_mux : '0;
            avs.readdatavalid <= avs.read;
            irq               <= |(key_edge & irq_mask);
        end
    end

    always_comb begin
        hex_next = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            hex_next[7*i +: 7] = hex_blank[i] ? 7'h7F : seg_glyph(hex_data[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex <= '1;
        end else begin
            hex <= hex_next;
        end
    end

endmodule
